// File: rtl/card_plot_arbiter.sv
// card_plot_arbiter: grants the single box plotter to a clear or a reveal job and
// draws up to three card slots per job. Define ARB_RR_EN for round-robin tie-break.
`timescale 1ns/1ps
module card_plot_arbiter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clr_req,
  input  logic [11:0] clr_cards,
  output logic        clr_ack,
  output logic        clr_done,
  input  logic        rev_req,
  input  logic [11:0] rev_cards,
  input  logic [2:0]  rev_colour,
  output logic        rev_ack,
  output logic        rev_done,
  output logic        plot_start,
  output logic [7:0]  plot_x0,
  output logic [6:0]  plot_y0,
  output logic [2:0]  plot_colour,
  input  logic        plot_done,
  output logic        busy
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_NEXT, S_DONE} state_t;
  typedef enum logic {OWN_CLR, OWN_REV} owner_t;

  state_t      state, state_nxt;
  owner_t      owner;
  logic [11:0] job;
  logic [1:0]  slot;
  logic [3:0]  card;
  logic        grant_clr, grant_rev;
  logic        map_valid;
  logic [7:0]  map_x;
  logic [6:0]  map_y;

`ifdef ARB_RR_EN
  owner_t last_grant;

  // A tie goes to whichever requester was not granted last.
  always_comb begin
    grant_clr = 1'b0;
    grant_rev = 1'b0;
    if (state == S_IDLE) begin
      if (clr_req && rev_req) begin
        grant_clr = (last_grant == OWN_REV);
        grant_rev = (last_grant == OWN_CLR);
      end else begin
        grant_clr = clr_req;
        grant_rev = rev_req;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       last_grant <= OWN_REV;
    else if (grant_clr) last_grant <= OWN_CLR;
    else if (grant_rev) last_grant <= OWN_REV;
  end
`else
  assign grant_clr = (state == S_IDLE) && clr_req;
  assign grant_rev = (state == S_IDLE) && rev_req && !clr_req;
`endif

  always_comb begin
    case (slot)
      2'd0:    card = job[3:0];
      2'd1:    card = job[7:4];
      default: card = job[11:8];
    endcase
  end

  // Card index to box origin on the 3x3 table grid; other indices draw nothing.
  always_comb begin
    map_valid = 1'b1;
    map_x     = 8'd0;
    map_y     = 7'd0;
    case (card)
      4'd1:    begin map_x = 8'd50; map_y = 7'd30; end
      4'd2:    begin map_x = 8'd70; map_y = 7'd30; end
      4'd3:    begin map_x = 8'd90; map_y = 7'd30; end
      4'd4:    begin map_x = 8'd50; map_y = 7'd50; end
      4'd5:    begin map_x = 8'd70; map_y = 7'd50; end
      4'd6:    begin map_x = 8'd90; map_y = 7'd50; end
      4'd7:    begin map_x = 8'd50; map_y = 7'd70; end
      4'd8:    begin map_x = 8'd70; map_y = 7'd70; end
      4'd9:    begin map_x = 8'd90; map_y = 7'd70; end
      default: map_valid = 1'b0;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      S_IDLE:  if (grant_clr || grant_rev) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = map_valid ? S_ISSUE : S_NEXT;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (plot_done) state_nxt = S_NEXT;
      S_NEXT:  state_nxt = (slot == 2'd2) ? S_DONE : S_LOAD;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      job         <= 12'd0;
      slot        <= 2'd0;
      owner       <= OWN_CLR;
      plot_colour <= 3'd0;
      plot_x0     <= 8'd0;
      plot_y0     <= 7'd0;
      clr_ack     <= 1'b0;
      rev_ack     <= 1'b0;
    end else begin
      clr_ack <= grant_clr;
      rev_ack <= grant_rev;
      if (grant_clr || grant_rev) begin
        job         <= grant_clr ? clr_cards : rev_cards;
        slot        <= 2'd0;
        owner       <= grant_clr ? OWN_CLR : OWN_REV;
        plot_colour <= grant_clr ? 3'b111 : rev_colour;
      end
      if (state == S_LOAD && map_valid) begin
        plot_x0 <= map_x;
        plot_y0 <= map_y;
      end
      if (state == S_NEXT) slot <= slot + 2'd1;
    end
  end

  assign plot_start = (state == S_ISSUE);
  assign busy       = (state != S_IDLE);
  assign clr_done   = (state == S_DONE) && (owner == OWN_CLR);
  assign rev_done   = (state == S_DONE) && (owner == OWN_REV);

endmodule

// File: tb/tb_card_plot_arbiter.sv
// Bench for card_plot_arbiter: job-level reference model (slot costs, grid arithmetic,
// arbitration rule) against directed and $urandom jobs, with an auto-responding plotter.
`timescale 1ns/1ps
module tb_card_plot_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clr_req = 1'b0, rev_req = 1'b0, plot_done = 1'b0;
  logic [11:0] clr_cards = 12'd0, rev_cards = 12'd0;
  logic [2:0]  rev_colour = 3'd0;
  logic        clr_ack, clr_done, rev_ack, rev_done, plot_start, busy;
  logic [7:0]  plot_x0;
  logic [6:0]  plot_y0;
  logic [2:0]  plot_colour;

  int total = 0, bad = 0, cyc = 0, pd_delay = 5;
  int pd_due[$], clr_ack_q[$], rev_ack_q[$], clr_done_q[$], rev_done_q[$], stc_q[$];
  logic [17:0] st_q[$];
  logic [17:0] last_start = 18'd0;
  bit tb_last_rev = 1'b1;

  always #5 clk = ~clk;

  card_plot_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .clr_req(clr_req), .clr_cards(clr_cards), .clr_ack(clr_ack), .clr_done(clr_done),
    .rev_req(rev_req), .rev_cards(rev_cards), .rev_colour(rev_colour),
    .rev_ack(rev_ack), .rev_done(rev_done),
    .plot_start(plot_start), .plot_x0(plot_x0), .plot_y0(plot_y0),
    .plot_colour(plot_colour), .plot_done(plot_done), .busy(busy)
  );

  task automatic check(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] box(input int idx, input logic [2:0] col);
    int x = 50 + 20 * ((idx - 1) % 3);
    int y = 30 + 20 * ((idx - 1) / 3);
    return {8'(x), 7'(y), col};
  endfunction

  function automatic bit win_clr(input bit cr, input bit rr);
`ifdef ARB_RR_EN
    if (cr && rr) return tb_last_rev;
`endif
    return cr;
  endfunction

  function automatic logic [11:0] rand_cards();
    return {4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
  endfunction

  task automatic clear_mon();
    clr_ack_q.delete(); rev_ack_q.delete(); clr_done_q.delete(); rev_done_q.delete();
    st_q.delete(); stc_q.delete();
  endtask

  // One clock: act as the plotter, then log every output event with its cycle.
  task automatic step();
    @(posedge clk); #1;
    cyc++;
    plot_done = 1'b0;
    if (pd_due.size() > 0 && pd_due[0] == cyc) begin
      void'(pd_due.pop_front());
      if (busy) check("hold_box", {plot_x0, plot_y0, plot_colour}, last_start);
      plot_done = 1'b1;
    end
    if (plot_start) begin
      last_start = {plot_x0, plot_y0, plot_colour};
      st_q.push_back(last_start);
      stc_q.push_back(cyc);
      pd_due.push_back(cyc + pd_delay);
    end
    if (clr_ack)  clr_ack_q.push_back(cyc);
    if (rev_ack)  rev_ack_q.push_back(cyc);
    if (clr_done) clr_done_q.push_back(cyc);
    if (rev_done) rev_done_q.push_back(cyc);
  endtask

  task automatic check_zero(input string tag);
    check(tag, {clr_ack, clr_done, rev_ack, rev_done, plot_start, busy,
                plot_x0, plot_y0, plot_colour}, 0);
  endtask

  // Request presented in the current (IDLE) cycle c. A valid slot costs
  // LOAD+ISSUE+delay+NEXT cycles, an empty slot LOAD+NEXT.
  task automatic expect_job(input bit own_clr, input logic [11:0] cards,
                            input logic [2:0] col, input bit scramble, input bit spur);
    int c = cyc;
    int l = cyc + 1;
    int budget = 400;
    int exp_sc[$], oa[$], na[$], od[$], nd[$];
    logic [17:0] exp_st[$];
    bit acked = 1'b0;
    for (int s = 0; s < 3; s++) begin
      int idx = int'((cards >> (4 * s)) & 12'hF);
      if (idx >= 1 && idx <= 9) begin
        exp_st.push_back(box(idx, col));
        exp_sc.push_back(l + 1);
        l += pd_delay + 3;
      end else begin
        l += 2;
      end
    end
    clear_mon();
    while (clr_done_q.size() + rev_done_q.size() == 0 && budget > 0) begin
      step();
      budget--;
      if (clr_ack_q.size() + rev_ack_q.size() > 0) acked = 1'b1;
      if (acked && scramble) begin
        clr_cards  = 12'($urandom);
        rev_cards  = 12'($urandom);
        rev_colour = 3'($urandom);
      end
      if (spur) foreach (exp_sc[i]) if (cyc == exp_sc[i] - 1 || cyc == exp_sc[i]) plot_done = 1'b1;
    end
    check("job_timeout", budget > 0, 1);
    if (own_clr) begin oa = clr_ack_q; na = rev_ack_q; od = clr_done_q; nd = rev_done_q; end
    else         begin oa = rev_ack_q; na = clr_ack_q; od = rev_done_q; nd = clr_done_q; end
    check("ack_count", oa.size(), 1);
    if (oa.size() > 0) check("ack_latency", oa[0] - c, 1);
    check("other_ack", na.size(), 0);
    check("done_count", od.size(), 1);
    if (od.size() > 0) check("done_latency", od[0] - c, l - c);
    check("other_done", nd.size(), 0);
    check("start_count", st_q.size(), exp_st.size());
    foreach (exp_st[i]) if (i < st_q.size()) begin
      check("start_box", st_q[i], exp_st[i]);
      check("start_cycle", stc_q[i] - c, exp_sc[i] - c);
    end
    tb_last_rev = !own_clr;
    step();
    check("idle_after_done", busy, 0);
  endtask

  task automatic run_current(input bit scramble, input bit spur);
    bit oc = win_clr(clr_req, rev_req);
    expect_job(oc, oc ? clr_cards : rev_cards, oc ? 3'b111 : rev_colour, scramble, spur);
  endtask

  initial begin
    int b;
    #12;
    check_zero("reset_outputs");
    reset_n = 1'b1;
    step(); step();
    check_zero("idle_outputs");

    // Both requesters rise together and stay high over two jobs.
    pd_delay = 3;
    clr_cards = 12'h0A5; rev_cards = 12'h900; rev_colour = 3'b101;
    clr_req = 1'b1; rev_req = 1'b1;
    check("first_winner_clear", win_clr(1'b1, 1'b1), 1);
    run_current(1'b0, 1'b0);
    run_current(1'b0, 1'b0);
    clr_req = 1'b0; rev_req = 1'b0;

    // Clear job drawing three boxes, plotter answers after 5 cycles.
    pd_delay = 5;
    clr_cards = 12'h951; clr_req = 1'b1;
    run_current(1'b0, 1'b0);
    clr_req = 1'b0;

    // Reveal job with no valid slot: minimum latency.
    rev_cards = 12'h0F0; rev_colour = 3'b010; rev_req = 1'b1;
    run_current(1'b0, 1'b0);
    rev_req = 1'b0;

    // Spurious plot_done in LOAD/ISSUE while the inputs change after ack.
    pd_delay = 2;
    clr_cards = 12'h268; clr_req = 1'b1;
    run_current(1'b1, 1'b1);
    clr_req = 1'b0;

    for (int k = 0; k < 10; k++) begin
      int pat = int'($urandom_range(0, 2));
      clr_req    = (pat != 1);
      rev_req    = (pat != 0);
      clr_cards  = rand_cards();
      rev_cards  = rand_cards();
      rev_colour = 3'($urandom);
      pd_delay   = int'($urandom_range(1, 5));
      run_current(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      clr_req = 1'b0; rev_req = 1'b0;
    end

    // Reset while waiting on the slot-1 box.
    pd_delay = 8;
    clr_cards = 12'h321; clr_req = 1'b1;
    clear_mon();
    step();
    clr_req = 1'b0;
    b = 100;
    while (stc_q.size() < 2 && b > 0) begin step(); b--; end
    check("slot1_reached", stc_q.size(), 2);
    if (st_q.size() > 1) check("slot1_box", st_q[1], box(2, 3'b111));
    step(); step();
    reset_n = 1'b0;
    #1;
    check_zero("async_reset_outputs");
    clear_mon();
    tb_last_rev = 1'b1;
    step();
    reset_n = 1'b1;
    repeat (12) step();
    check("post_reset_done", clr_done_q.size() + rev_done_q.size(), 0);
    check("post_reset_activity", st_q.size() + clr_ack_q.size() + rev_ack_q.size(), 0);
    check("post_reset_busy", busy, 0);
    check("stale_done_delivered", pd_due.size(), 0);

    pd_delay = 3;
    clr_cards = 12'h074; clr_req = 1'b1;
    run_current(1'b0, 1'b0);
    clr_req = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
